dcache_nway: RTL

- Parametrised write-back, write-allocate data cache: N-way set associative, configurable set count and block size, true-LRU replacement.
- Sits between the datapath memory port and the memory arbiter.
- On halt it flushes every dirty block, optionally writes a hit/miss statistic, then asserts flushed.
- Successor to the fixed 8-set/2-way/2-word data cache.

---
 rtl/dcache_nway.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/dcache_nway.sv
// N-way set-associative write-back data cache with true-LRU replacement and halt-time flush.
// Define STATS_EN to add hit/miss counters and the statistic write to STAT_ADDR before halting.
module dcache_nway #(
    parameter int          SETS      = 8,
    parameter int          WAYS      = 2,
    parameter int          BLKWORDS  = 2,
    parameter logic [31:0] STAT_ADDR = 32'h3100
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        halt,
    input  logic        dmemREN,
    input  logic        dmemWEN,
    input  logic [31:0] dmemaddr,
    input  logic [31:0] dmemstore,
    output logic        dhit,
    output logic [31:0] dmemload,
    output logic        flushed,
    input  logic        dwait,
    input  logic [31:0] dload,
    output logic        dREN,
    output logic        dWEN,
    output logic [31:0] daddr,
    output logic [31:0] dstore
);
    localparam int OB   = $clog2(BLKWORDS);
    localparam int IB   = $clog2(SETS);
    localparam int WAYB = $clog2(WAYS);
    localparam int TW   = 30 - OB - IB;
    localparam int OW   = (OB > 0) ? OB : 1;
    localparam int WW   = (WAYB > 0) ? WAYB : 1;
    localparam int LCW  = IB + WAYB + 1;

    typedef enum logic [2:0] {IDLE, WB, LD, FSCAN, FWB, COUNT, HALTED} state_t;

    state_t           state;
    logic [WW-1:0]    vic;
    logic [OW-1:0]    wc;
    logic [LCW-1:0]   lc;

    logic             valid_q [SETS][WAYS];
    logic             dirty_q [SETS][WAYS];
    logic [WW-1:0]    age_q   [SETS][WAYS];
    logic [TW-1:0]    tag_q   [SETS][WAYS];
    logic [31:0]      data_q  [SETS][WAYS][BLKWORDS];

    logic [TW-1:0]    req_tag;
    logic [IB-1:0]    req_idx, f_set;
    logic [OW-1:0]    req_off;
    logic [WW-1:0]    hit_way, vic_c, f_way;
    logic             hit_any, last, req;
    logic [31:0]      stat_word;

    assign req_tag = TW'(dmemaddr >> (2 + OB + IB));
    assign req_idx = IB'(dmemaddr >> (2 + OB));
    assign req_off = OW'(dmemaddr >> 2) & OW'(BLKWORDS - 1);
    assign f_set   = IB'(lc >> WAYB);
    assign f_way   = WW'(lc) & WW'(WAYS - 1);
    assign last    = (wc == OW'(BLKWORDS - 1));
    assign req     = dmemREN | dmemWEN;

    function automatic logic [31:0] mk_addr(input logic [TW-1:0] t, input logic [IB-1:0] i,
                                            input logic [OW-1:0] o);
        return (32'(t) << (2 + OB + IB)) | (32'(i) << (2 + OB)) | (32'(o) << 2);
    endfunction

    // NOTE: every variable in an always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        hit_any = 1'b0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++)
            if (valid_q[req_idx][w] && tag_q[req_idx][w] == req_tag) begin
                hit_any = 1'b1;
                hit_way = WW'(w);
            end
    end

    // Victim: lowest-index invalid way, else the oldest (age WAYS-1).
    always_comb begin
        logic found;
        found = 1'b0;
        vic_c = '0;
        for (int w = 0; w < WAYS; w++)
            if (!valid_q[req_idx][w] && !found) begin
                vic_c = WW'(w);
                found = 1'b1;
            end
        if (!found)
            for (int w = 0; w < WAYS; w++)
                if (age_q[req_idx][w] == WW'(WAYS - 1)) vic_c = WW'(w);
    end

    assign dhit     = (state == IDLE) && !halt && req && hit_any;
    assign dmemload = (dhit && !dmemWEN) ? data_q[req_idx][hit_way][req_off] : '0;

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
            vic   <= '0;
            wc    <= '0;
            lc    <= '0;
            for (int s = 0; s < SETS; s++)
                for (int w = 0; w < WAYS; w++) begin
                    valid_q[s][w] <= 1'b0;
                    dirty_q[s][w] <= 1'b0;
                    age_q[s][w]   <= WW'(w);  // a valid age permutation from the start
                end
        end else begin
            case (state)
                IDLE: begin
                    if (halt) begin
                        lc    <= '0;
                        state <= FSCAN;
                    end else if (req && hit_any) begin
                        if (dmemWEN) dirty_q[req_idx][hit_way] <= 1'b1;
                        for (int w = 0; w < WAYS; w++)
                            if (WW'(w) == hit_way)
                                age_q[req_idx][w] <= '0;
                            else if (age_q[req_idx][w] < age_q[req_idx][hit_way])
                                age_q[req_idx][w] <= age_q[req_idx][w] + WW'(1);
                    end else if (req) begin
                        vic   <= vic_c;
                        wc    <= '0;
                        state <= (valid_q[req_idx][vic_c] && dirty_q[req_idx][vic_c]) ? WB : LD;
                    end
                end
                WB: if (!dwait) begin
                    wc <= last ? '0 : wc + OW'(1);
                    if (last) state <= LD;
                end
                LD: if (!dwait) begin
                    wc <= last ? '0 : wc + OW'(1);
                    if (last) begin
                        valid_q[req_idx][vic] <= 1'b1;
                        dirty_q[req_idx][vic] <= 1'b0;
                        state                 <= IDLE;
                    end
                end
                FSCAN: begin
                    if (lc == LCW'(SETS * WAYS)) begin
`ifdef STATS_EN
                        state <= COUNT;
`else
                        state <= HALTED;
`endif
                    end else if (dirty_q[f_set][f_way]) begin
                        wc    <= '0;
                        state <= FWB;
                    end else begin
                        lc <= lc + LCW'(1);
                    end
                end
                FWB: if (!dwait) begin
                    wc <= last ? '0 : wc + OW'(1);
                    if (last) begin
                        valid_q[f_set][f_way] <= 1'b0;
                        dirty_q[f_set][f_way] <= 1'b0;
                        lc                    <= lc + LCW'(1);
                        state                 <= FSCAN;
                    end
                end
                COUNT:   if (!dwait) state <= HALTED;
                HALTED:  ;
                default: state <= IDLE;
            endcase
        end
    end

    // NOTE: tag and data arrays are plain storage without reset; valid bits alone decide what is live.
    always_ff @(posedge CLK) begin
        if (dhit && dmemWEN) data_q[req_idx][hit_way][req_off] <= dmemstore;
        if (state == LD && !dwait) begin
            data_q[req_idx][vic][wc] <= dload;
            if (last) tag_q[req_idx][vic] <= req_tag;
        end
    end

`ifdef STATS_EN
    logic [31:0] hit_count, miss_count;
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (dhit) hit_count <= hit_count + 32'd1;
            if (state == LD && !dwait && last) miss_count <= miss_count + 32'd1;
        end
    end
    assign stat_word = hit_count - miss_count;
`else
    assign stat_word = '0;
`endif

    // Memory-side outputs depend only on registered state, so reset drops them at once.
    always_comb begin
        dREN    = 1'b0;
        dWEN    = 1'b0;
        daddr   = '0;
        dstore  = '0;
        flushed = 1'b0;
        case (state)
            WB: begin
                dWEN   = 1'b1;
                daddr  = mk_addr(tag_q[req_idx][vic], req_idx, wc);
                dstore = data_q[req_idx][vic][wc];
            end
            LD: begin
                dREN  = 1'b1;
                daddr = mk_addr(req_tag, req_idx, wc);
            end
            FWB: begin
                dWEN   = 1'b1;
                daddr  = mk_addr(tag_q[f_set][f_way], f_set, wc);
                dstore = data_q[f_set][f_way][wc];
            end
            COUNT: begin
                dWEN   = 1'b1;
                daddr  = STAT_ADDR;
                dstore = stat_word;
            end
            HALTED:  flushed = 1'b1;
            default: ;
        endcase
    end
endmodule
